// File: rtl/hsv_converter_pkg.sv
// hsv_pkg: shared state/channel types and hue sector constants for hsv_converter.
package hsv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    DIV_HUE,
    DIV_SAT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RED,
    GREEN,
    BLUE
  } chan_e;

  // Hue sector bases in units of one 60 degree sextant.
  localparam int unsigned SECT_BASE_R = 0;
  localparam int unsigned SECT_BASE_G = 2;
  localparam int unsigned SECT_BASE_B = 4;
  localparam int unsigned SECT_COUNT  = 6;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hsv_converter_if.sv
// hsv_converter_if: pixel-in / result-out handshake bundle for hsv_converter.
interface hsv_converter_if #(
  parameter int CW = 5,
  parameter int HF = 4,
  parameter int SW = 5
);

  logic            in_valid;
  logic            in_ready;
  logic [3*CW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [HF+2:0]   hue;
  logic [SW-1:0]   saturation;
  logic [CW-1:0]   value;
  logic            hue_invalid;

  // Upstream / downstream side (pixel source and result sink).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, hue, saturation, value, hue_invalid
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, hue, saturation, value, hue_invalid
  );

endinterface

// File: rtl/hsv_converter_seqdiv.sv
// hsv_seqdiv: iterative restoring unsigned divider, one quotient bit per cycle.
// The caller picks the quotient length per divide (len); the dividend must
// satisfy dividend >> len < divisor so the quotient fits in len bits.
// start loads the operands and performs the first step in the same cycle, so a
// len-bit quotient is valid (done high) len cycles after start is sampled.
module hsv_seqdiv #(
  parameter int DW = 10,
  parameter int VW = 5,
  parameter int QW = 6,
  parameter int LW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  logic [VW-1:0] rem_q, rem_d, rem_src;
  logic [DW-1:0] dq_q, dq_d, dq_src;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [VW:0]   trial;
  logic          take;

  assign busy     = (cnt_q != '0);
  assign done     = done_q;
  assign quotient = dq_q[QW-1:0];

  // Restoring step on either the freshly loaded operands or the running state.
  always_comb begin
    rem_src = rem_q;
    dq_src  = dq_q;
    if (start) begin
      rem_src = VW'(dividend >> len);
      dq_src  = dividend << (LW'(DW) - len);
    end
    trial  = {rem_src, dq_src[DW-1]};
    take   = (trial >= {1'b0, divisor});
    rem_d  = rem_q;
    dq_d   = dq_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start || busy) begin
      rem_d = take ? VW'(trial - {1'b0, divisor}) : trial[VW-1:0];
      dq_d  = {dq_src[DW-2:0], take};
      if (start) begin
        cnt_d  = len - LW'(1);
        done_d = (len == LW'(1));
      end else begin
        cnt_d  = cnt_q - LW'(1);
        done_d = (cnt_q == LW'(1));
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rem_q  <= '0;
      dq_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dq_q   <= dq_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/hsv_converter.sv
// hsv_converter: handshaked RGB-to-HSV converter with a shared iterative divider.
// Optional feature macro HSV_SAT_EN: when defined, saturation is computed in a
// second divide (DIV_SAT); when undefined, that state is skipped and saturation
// is tied to 0.
//
// state   | meaning
// IDLE    | waiting for a pixel, in_ready high
// COMPARE | pick max/min of latched pixel, launch hue divide
// DIV_HUE | hue quotient iterating (HF+1 cycles)
// DIV_SAT | saturation quotient iterating (SW+1 cycles)
// DONE    | result held, out_valid high until out_ready
module hsv_converter
  import hsv_pkg::*;
#(
  parameter int CW = 5,
  parameter int HF = 4,
  parameter int SW = 5
) (
  input logic            clk,
  input logic            res,
  hsv_converter_if.slave bus
);

  localparam int MW = max_i(HF, SW);
  localparam int DW = CW + MW;
  localparam int QW = MW + 1;
  localparam int LW = $clog2(DW + 1);
  localparam int HW = HF + 3;

  localparam logic [HW-1:0] HUE_FULL   = HW'(SECT_COUNT << HF);
  localparam logic [HW-1:0] HUE_BASE_R = HW'(SECT_BASE_R << HF);
  localparam logic [HW-1:0] HUE_BASE_G = HW'(SECT_BASE_G << HF);
  localparam logic [HW-1:0] HUE_BASE_B = HW'(SECT_BASE_B << HF);

  state_e        state_q, state_d;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [HW-1:0] hue_q, hue_d;
  logic [CW-1:0] value_q, value_d;
  logic          inv_q, inv_d;

  chan_e         max_sel;
  logic [CW-1:0] max_val, min_val, d_val;
  logic [CW-1:0] num_a, num_b, n_mag;
  logic          n_neg;
  logic          achrom;
  logic [DW-1:0] hue_dividend;
  logic [HW-1:0] q_h, hue_calc;

  logic          div_start, div_busy, div_done;
  logic [LW-1:0] div_len;
  logic [DW-1:0] div_dividend;
  logic [CW-1:0] div_divisor;
  logic [QW-1:0] div_q;

`ifdef HSV_SAT_EN
  logic [HW-1:0] hue_mid_q, hue_mid_d;
  logic [SW-1:0] sat_q, sat_d;
  logic [SW-1:0] sat_calc;
  logic [DW-1:0] sat_dividend;
`endif

  hsv_seqdiv #(
    .DW(DW),
    .VW(CW),
    .QW(QW),
    .LW(LW)
  ) u_div (
    .clk     (clk),
    .res     (res),
    .start   (div_start),
    .len     (div_len),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  // Max/min selection (R > G > B on ties), chroma and signed hue numerator.
  always_comb begin
    if (r_q >= g_q && r_q >= b_q) begin
      max_sel = RED;
      max_val = r_q;
      num_a   = g_q;
      num_b   = b_q;
    end else if (g_q >= b_q) begin
      max_sel = GREEN;
      max_val = g_q;
      num_a   = b_q;
      num_b   = r_q;
    end else begin
      max_sel = BLUE;
      max_val = b_q;
      num_a   = r_q;
      num_b   = g_q;
    end
    min_val = r_q;
    if (g_q < min_val) min_val = g_q;
    if (b_q < min_val) min_val = b_q;
    d_val        = max_val - min_val;
    achrom       = (max_val == min_val);
    n_neg        = (num_a < num_b);
    n_mag        = n_neg ? (num_b - num_a) : (num_a - num_b);
    hue_dividend = DW'(n_mag) << HF;
  end

  // Fold the hue quotient into the sector of the max channel; a full circle wraps to 0.
  always_comb begin
    q_h = HW'(div_q);
    case (max_sel)
      RED:     hue_calc = n_neg ? (HUE_FULL - q_h) : (HUE_BASE_R + q_h);
      GREEN:   hue_calc = n_neg ? (HUE_BASE_G - q_h) : (HUE_BASE_G + q_h);
      default: hue_calc = n_neg ? (HUE_BASE_B - q_h) : (HUE_BASE_B + q_h);
    endcase
    if (hue_calc == HUE_FULL) hue_calc = '0;
  end

`ifdef HSV_SAT_EN
  // Saturation dividend and clamp of the (at most 2^SW) quotient.
  always_comb begin
    sat_dividend = DW'(d_val) << SW;
    if (div_q[QW-1:SW] != '0) sat_calc = '1;
    else                      sat_calc = div_q[SW-1:0];
  end
`endif

  // Next-state, divider control and result capture.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    hue_d        = hue_q;
    value_d      = value_q;
    inv_d        = inv_q;
    div_start    = 1'b0;
    div_len      = LW'(HF + 1);
    div_dividend = hue_dividend;
    div_divisor  = d_val;
`ifdef HSV_SAT_EN
    hue_mid_d    = hue_mid_q;
    sat_d        = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          {r_d, g_d, b_d} = bus.in_data;
          state_d         = COMPARE;
        end
      end
      COMPARE: begin
        div_start = 1'b1;
        state_d   = DIV_HUE;
      end
      DIV_HUE: begin
        if (div_done && !div_busy) begin
`ifdef HSV_SAT_EN
          hue_mid_d    = hue_calc;
          div_start    = 1'b1;
          div_len      = LW'(SW + 1);
          div_dividend = sat_dividend;
          div_divisor  = max_val;
          state_d      = DIV_SAT;
`else
          hue_d   = achrom ? '0 : hue_calc;
          value_d = max_val;
          inv_d   = achrom;
          state_d = DONE;
`endif
        end
      end
      DIV_SAT: begin
`ifdef HSV_SAT_EN
        if (div_done && !div_busy) begin
          hue_d   = achrom ? '0 : hue_mid_q;
          sat_d   = achrom ? '0 : sat_calc;
          value_d = max_val;
          inv_d   = achrom;
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pixel and result registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hue_q     <= '0;
      value_q   <= '0;
      inv_q     <= 1'b0;
`ifdef HSV_SAT_EN
      hue_mid_q <= '0;
      sat_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hue_q     <= hue_d;
      value_q   <= value_d;
      inv_q     <= inv_d;
`ifdef HSV_SAT_EN
      hue_mid_q <= hue_mid_d;
      sat_q     <= sat_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.hue         = hue_q;
  assign bus.value       = value_q;
  assign bus.hue_invalid = inv_q;
`ifdef HSV_SAT_EN
  assign bus.saturation  = sat_q;
`else
  assign bus.saturation  = '0;
`endif

endmodule

// File: tb/tb_hsv_converter.sv
// tb_hsv_converter: directed vectors with hand-computed HSV results.
module tb_hsv_converter;

  localparam int CW = 5;
  localparam int HF = 4;
  localparam int SW = 5;
`ifdef HSV_SAT_EN
  localparam int LAT    = HF + SW + 3;
  localparam bit SAT_ON = 1'b1;
`else
  localparam int LAT    = HF + 2;
  localparam bit SAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  hsv_converter_if #(.CW(CW), .HF(HF), .SW(SW)) bus ();

  hsv_converter #(.CW(CW), .HF(HF), .SW(SW)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Offer one pixel, check latency and result, optionally stall, then accept it.
  task automatic run_px(input string tag, input int r, input int g, input int b,
                        input int e_hue, input int e_sat, input int e_val,
                        input int e_inv, input int hold);
    int cyc;
    int s_exp;
    logic [4:0] rr, gg, bb;
    s_exp = SAT_ON ? e_sat : 0;
    rr = 5'(r);
    gg = 5'(g);
    bb = 5'(b);
    chk({tag, ".rdy"}, 32'(bus.in_ready), 1);
    bus.in_data  = {rr, gg, bb};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '1;
    chk({tag, ".busy"}, 32'(bus.in_ready), 0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".lat"}, cyc, LAT);
    chk({tag, ".hue"}, 32'(bus.hue), e_hue);
    chk({tag, ".sat"}, 32'(bus.saturation), s_exp);
    chk({tag, ".val"}, 32'(bus.value), e_val);
    chk({tag, ".inv"}, 32'(bus.hue_invalid), e_inv);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_ov"}, 32'(bus.out_valid), 1);
      chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 0);
      chk({tag, ".hold_hue"}, 32'(bus.hue), e_hue);
      chk({tag, ".hold_val"}, 32'(bus.value), e_val);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".ack_rdy"}, 32'(bus.in_ready), 1);
    chk({tag, ".ack_ov"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst.ov", 32'(bus.out_valid), 0);
    chk("rst.hue", 32'(bus.hue), 0);
    chk("rst.sat", 32'(bus.saturation), 0);
    chk("rst.val", 32'(bus.value), 0);
    chk("rst.inv", 32'(bus.hue_invalid), 0);
    chk("rst.rdy", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    res = 1'b0;
    @(posedge clk);
    #1;

    //       tag        r   g   b  hue sat val inv hold
    run_px("red",      31,  0,  0,  0, 31, 31, 0, 0);
    run_px("green",     0, 31,  0, 32, 31, 31, 0, 0);
    run_px("blue",      0,  0, 31, 64, 31, 31, 0, 0);
    run_px("orange",   31, 16,  0,  8, 31, 31, 0, 0);
    run_px("magenta",  31,  0, 31, 80, 31, 31, 0, 0);
    run_px("dullred",  20, 10, 10,  0, 16, 20, 0, 0);
    run_px("gray",     10, 10, 10,  0,  0, 10, 1, 0);
    run_px("black",     0,  0,  0,  0,  0,  0, 1, 0);
    run_px("cyan",      0, 31, 31, 48, 31, 31, 0, 0);
    run_px("wrap",     31,  0,  1,  0, 31, 31, 0, 0);
    run_px("gneg",     10, 20,  5, 27, 24, 20, 0, 0);
    run_px("rneg",     20,  5, 10, 91, 24, 20, 0, 0);
    run_px("bpress",    5, 10, 20, 59, 24, 20, 0, 5);

    // Reset in the middle of a divide: outputs clear at once, nothing is emitted.
    bus.in_data  = {5'd31, 5'd16, 5'd0};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    res = 1'b1;
    #1;
    chk("abort.ov", 32'(bus.out_valid), 0);
    chk("abort.hue", 32'(bus.hue), 0);
    chk("abort.val", 32'(bus.value), 0);
    chk("abort.rdy", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    res = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("abort.noout", seen, 0);
    run_px("after",    31, 16,  0,  8, 31, 31, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hsv_converter.md
# hsv_converter

Parametrised, handshaked RGB-to-HSV converter for the ball-detector pixel path. It sits between the camera pixel unpacker and the colour classifier. It accepts one packed {r,g,b} pixel, selects max and min, and computes hue and saturation with a shared iterative divider. It returns value, hue, saturation and an achromatic flag behind a valid/ready output stage.

## Interface
- CW, 5: bits per colour channel; legal range 2..8.
- HF, 4: hue fraction bits per 60° sextant; legal range 1..6. A full hue circle is 6·2^HF codes.
- SW, 5: saturation width; legal range 1..8.
- clk  in  1  clock; all state updates on its rising edge.
- res  in  1  reset, asynchronous and active-high.
- in_valid  in  1  pixel offered.
- in_ready  out  1  block idle and able to accept a pixel; high exactly when state is IDLE.
- in_data  in  3·CW  packed pixel {r,g,b}, with r in the MSBs.
- out_valid  out  1  result held on the output ports.
- out_ready  in  1  downstream accepts the result.
- hue  out  HF+3  hue code, range 0..6·2^HF−1.
- saturation  out  SW  saturation, 0..2^SW−1.
- value  out  CW  max(r,g,b).
- hue_invalid  out  1  achromatic pixel (max==min); hue is forced to 0.

## Operation
- States: IDLE, COMPARE, DIV_HUE, DIV_SAT, DONE.
- IDLE: on in_valid && in_ready, latch r, g, b and go to COMPARE.
- COMPARE (1 cycle):
  - Max priority on ties is R > G > B; min uses the same priority.
  - Compute d = max−min and the signed numerator n: max=R gives g−b, max=G gives b−r, max=B gives r−g.
  - Load the divider with |n|·2^HF / d, then go to DIV_HUE.
- DIV_HUE (HF+1 cycles): produces one quotient bit per cycle; q ≤ 2^HF.
  - max=R, n≥0: hue = q.
  - max=R, n<0: hue = 6·2^HF − q. A result of 6·2^HF wraps to 0.
  - max=G: hue = 2·2^HF + sign(n)·q.
  - max=B: hue = 4·2^HF + sign(n)·q.
- DIV_SAT (SW+1 cycles): s = d·2^SW / max, clamped to 2^SW−1.
- Achromatic and black pixels run the full sequence; the divider result is discarded.
  - max==min: hue=0, saturation=0, hue_invalid=1.
  - max==0 is a subcase of the above; value=0.
- Arithmetic is unsigned. The divider dividend is CW+max(HF,SW) bits and the divisor is CW bits. Division by zero never reaches the output.
- DONE: out_valid=1 and all outputs held stable until out_ready. On the handshake, go to IDLE.
- Outputs are registered and change only on entry to DONE.

## Timing
- Reset values: out_valid=0, hue=0, saturation=0, value=0, hue_invalid=0, state=IDLE, in_ready=1.
- Latency is data-independent. out_valid first reads high HF+SW+3 cycles after the acceptance edge; the default is 12.
- in_ready goes low the cycle after acceptance. It returns high the cycle after the out_valid && out_ready edge. There is no same-cycle bypass, so minimum spacing is HF+SW+5 cycles per pixel.
- Back-pressure: out_ready low holds DONE indefinitely with outputs frozen.
- in_data is ignored outside IDLE.
- res asserted in any state clears everything immediately. It aborts the divide, and no partial result is emitted.

## Configuration
- HSV_SAT_EN defined: behaviour as above.
- HSV_SAT_EN undefined:
  - DIV_SAT is removed.
  - saturation is tied to 0.
  - Latency becomes HF+2 cycles.
  - Minimum pixel spacing becomes HF+4 cycles.

## Structure
- Package hsv_pkg holds:
  - the state enum;
  - the channel-select enum RED/GREEN/BLUE;
  - the sector base constants 0, 2 and 4.
- Sub-module hsv_seqdiv: iterative restoring unsigned divider with parametrised dividend, divisor and quotient widths, and a start/busy/done handshake. It is shared between the hue and saturation divides.

## Test plan
All scenarios use defaults CW=5, HF=4, SW=5, so hue range is 0..95.
- Pure red (31,0,0) -> hue 0, saturation 31, value 31, hue_invalid 0, out_valid at cycle 12.
- Green (0,31,0) -> hue 32; blue (0,0,31) -> hue 64; orange (31,16,0) -> hue 8, saturation 31.
- Magenta (31,0,31) -> R wins the tie, hue 80, saturation 31. Then (20,10,10) -> hue 0, saturation 16, value 20.
- Gray (10,10,10) -> hue 0, saturation 0, value 10, hue_invalid 1. Black (0,0,0) -> all 0 with hue_invalid 1.
- Back-pressure: out_ready low for 5 cycles after out_valid -> outputs stable and in_ready 0. Release -> in_ready 1 on the next cycle, then accept the next pixel.
- Assert res in cycle 6 of a divide -> out_valid 0 and outputs 0 at once. After release, in_ready=1 and a new pixel converts correctly.
